// File: rtl/aqp_pdm_pkg.sv
// ----------------------------------------------------------------------------
// aqp_pdm_pkg
// Shared constants, comb FSM state type and output saturation helper for the
// PDM microphone decimator (aqp_pdm_decimator, aqp_cic3_decim).
// No ports.
// ----------------------------------------------------------------------------
package aqp_pdm_pkg;

    localparam int unsigned CIC_W      = 20;
    localparam int unsigned CIC_ORDER  = 3;
    localparam int unsigned DECIM_LOG2 = 6;
    localparam int unsigned OUT_SHIFT  = 3;

    typedef enum logic [2:0] {
        CS_IDLE,
        CS_COMB1,
        CS_COMB2,
        CS_COMB3,
        CS_OUT
    } comb_state_e;

    localparam logic signed [CIC_W-1:0] SAT_HI = 32767;
    localparam logic signed [CIC_W-1:0] SAT_LO = -32768;

    // c3 spans +/-2^18; after the shift only +32768 can exceed 16 bits, but
    // both rails are clamped so the helper stays safe for any 20-bit input.
    function automatic logic [15:0] sat16(input logic signed [CIC_W-1:0] v);
        logic signed [CIC_W-1:0] s;
        s = v >>> OUT_SHIFT;
        if (s > SAT_HI) begin
            return 16'h7FFF;
        end else if (s < SAT_LO) begin
            return 16'h8000;
        end
        return s[15:0];
    endfunction

endpackage

// File: rtl/aqp_cic3_decim.sv
// ----------------------------------------------------------------------------
// aqp_cic3_decim
// One channel of the 3rd-order CIC decimator: three integrators running at the
// channel bit rate, a snapshot register taken at the decimation tick, and a
// three-stage comb sequenced by the parent FSM, followed by shift/saturate.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   bit_valid_i  one-clk strobe: bit_i is this channel's captured PDM bit
//   bit_i        captured PDM bit (1 -> +1, 0 -> -1)
//   tick_i       decimation tick; snapshots the integrator output
//   stage_i      comb stage select from the parent FSM
//   out_o        16-bit signed PCM sample, held between updates
// ----------------------------------------------------------------------------
module aqp_cic3_decim
    import aqp_pdm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_valid_i,
    input  logic        bit_i,
    input  logic        tick_i,
    input  comb_state_e stage_i,
    output logic [15:0] out_o
);

    typedef logic signed [CIC_W-1:0] cic_t;

    cic_t        x;
    cic_t        i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    cic_t        snap_q, snap_d;
    cic_t        d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    cic_t        acc_q, acc_d;
    logic [15:0] out_q, out_d;

    always_comb begin
        x      = bit_i ? CIC_W'(1) : '1;
        i1_d   = i1_q;
        i2_d   = i2_q;
        i3_d   = i3_q;
        snap_d = snap_q;
        d1_d   = d1_q;
        d2_d   = d2_q;
        d3_d   = d3_q;
        acc_d  = acc_q;
        out_d  = out_q;

        // Each stage consumes the previous stage's pre-update value;
        // modulo-2^20 wrap is harmless because the comb differences undo it.
        if (bit_valid_i) begin
            i1_d = i1_q + x;
            i2_d = i2_q + i1_q;
            i3_d = i3_q + i2_q;
        end

        // Snapshot includes a bit captured on the tick edge itself, so the
        // comb sees exactly the bits received up to the tick.
        if (tick_i) begin
            snap_d = i3_d;
        end

        // A single accumulator carries c1 -> c2 -> c3 through the stages.
        case (stage_i)
            CS_COMB1: begin
                acc_d = snap_q - d1_q;
                d1_d  = snap_q;
            end
            CS_COMB2: begin
                acc_d = acc_q - d2_q;
                d2_d  = acc_q;
            end
            CS_COMB3: begin
                acc_d = acc_q - d3_q;
                d3_d  = acc_q;
            end
            CS_OUT: begin
                out_d = sat16(acc_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1_q   <= '0;
            i2_q   <= '0;
            i3_q   <= '0;
            snap_q <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            d3_q   <= '0;
            acc_q  <= '0;
            out_q  <= '0;
        end else begin
            i1_q   <= i1_d;
            i2_q   <= i2_d;
            i3_q   <= i3_d;
            snap_q <= snap_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            d3_q   <= d3_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/aqp_pdm_decimator.sv
// ----------------------------------------------------------------------------
// aqp_pdm_decimator
// PDM microphone receiver: generates pdm_clk, synchronizes the shared stereo
// data line, captures left bits on pdm_clk falling and right bits on pdm_clk
// rising, and decimates each channel by DECIM with a CIC3 into 16-bit PCM.
//
// Build option: define AQP_PDM_STEREO_EN to build an independent right-channel
// filter. Otherwise only the left filter exists and right_data mirrors it.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   enable        capture enable; low parks pdm_clk low and freezes filters
//   pdm_clk       microphone bit clock, period 2*CLK_DIV clk
//   pdm_data      asynchronous PDM data, left/right interleaved
//   left_data     latest left sample (signed)
//   right_data    latest right sample (signed)
//   sample_valid  one-clk pulse when left_data/right_data update
// ----------------------------------------------------------------------------
module aqp_pdm_decimator
    import aqp_pdm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5,
    parameter int unsigned DECIM   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        pdm_clk,
    input  logic        pdm_data,
    output logic [15:0] left_data,
    output logic [15:0] right_data,
    output logic        sample_valid
);

    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned DCNT_W = $clog2(DECIM);

    logic [1:0]        sync_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              phase_q, phase_d;
    logic              pdm_clk_q, pdm_clk_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    comb_state_e       state_q, state_d;
    logic              valid_q, valid_d;

    logic              tc;
    logic              left_cap;
    logic              right_cap;
    logic              tick;
    logic              pdm_bit;

    assign pdm_bit   = sync_q[1];
    assign tc        = enable && (div_q == DIV_W'(CLK_DIV - 1));
    assign left_cap  = tc && phase_q;
    assign right_cap = tc && !phase_q;
    assign tick      = right_cap && (dcnt_q == '1);

    // phase_q keeps the divider phase across a disable while the output
    // register is parked low, so re-enable resumes where it left off.
    always_comb begin
        div_d     = div_q;
        phase_d   = phase_q;
        dcnt_d    = dcnt_q;
        if (enable) begin
            div_d = tc ? '0 : div_q + DIV_W'(1);
        end
        if (tc) begin
            phase_d = ~phase_q;
        end
        if (right_cap) begin
            dcnt_d = dcnt_q + DCNT_W'(1);
        end
        pdm_clk_d = enable && phase_d;
    end

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        case (state_q)
            CS_IDLE:  if (tick) state_d = CS_COMB1;
            CS_COMB1: state_d = CS_COMB2;
            CS_COMB2: state_d = CS_COMB3;
            CS_COMB3: state_d = CS_OUT;
            CS_OUT: begin
                state_d = CS_IDLE;
                valid_d = 1'b1;
            end
            default:  state_d = CS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            div_q     <= '0;
            phase_q   <= 1'b0;
            pdm_clk_q <= 1'b0;
            dcnt_q    <= '0;
            state_q   <= CS_IDLE;
            valid_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pdm_data};
            div_q     <= div_d;
            phase_q   <= phase_d;
            pdm_clk_q <= pdm_clk_d;
            dcnt_q    <= dcnt_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
        end
    end

    assign pdm_clk      = pdm_clk_q;
    assign sample_valid = valid_q;

    aqp_cic3_decim u_cic_left (
        .clk         (clk),
        .reset       (reset),
        .bit_valid_i (left_cap),
        .bit_i       (pdm_bit),
        .tick_i      (tick),
        .stage_i     (state_q),
        .out_o       (left_data)
    );

`ifdef AQP_PDM_STEREO_EN
    aqp_cic3_decim u_cic_right (
        .clk         (clk),
        .reset       (reset),
        .bit_valid_i (right_cap),
        .bit_i       (pdm_bit),
        .tick_i      (tick),
        .stage_i     (state_q),
        .out_o       (right_data)
    );
`else
    assign right_data = left_data;
`endif

endmodule

// File: tb/tb_aqp_pdm_decimator.sv
// ----------------------------------------------------------------------------
// tb_aqp_pdm_decimator
// Self-checking bench: a PDM source reacting to pdm_clk edges drives the data
// line, and a reference model built from cumulative sums predicts every PCM
// sample (exact third difference of the triple running sum, then shift and
// clamp). Constant-pattern runs also check the documented steady-state values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aqp_pdm_decimator;

    localparam int CLK_DIV = 5;
    localparam int DECIM   = 64;
    localparam int PERIOD  = 2 * CLK_DIV * DECIM;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        pdm_data = 1'b0;
    logic        pdm_clk;
    logic [15:0] left_data;
    logic [15:0] right_data;
    logic        sample_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aqp_pdm_decimator #(
        .CLK_DIV (CLK_DIV),
        .DECIM   (DECIM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pdm_clk      (pdm_clk),
        .pdm_data     (pdm_data),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Source/model state. mode: 0 random, 1 all ones, 2 all zeros,
    // 3 per-channel alternating, 4 left ones / right zeros.
    int     mode = 1;
    longint s1[2], s2[2], s3[2];
    longint hist[2][4];
    int     drv_cnt[2];
    int     rcount, sample_idx, cyc, last_valid;
    int     tick_cnt = 0, fall_cnt = 0, valid_in_reset = 0;
    bit     clear_period = 0;
    logic   cur_bit;
    logic   prev_pclk;
    longint expq_l[$], expq_r[$];

    function automatic longint clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic gen_bit(input int ch, output logic b);
        case (mode)
            0:       b = 1'($urandom & 1);
            1:       b = 1'b1;
            2:       b = 1'b0;
            3:       b = (drv_cnt[ch] % 2 == 0);
            default: b = (ch == 0);
        endcase
        drv_cnt[ch]++;
    endtask

    // Triple running sum where each level accumulates the lower level's
    // value from before this bit.
    task automatic consume(input int ch, input logic b);
        longint x;
        x = b ? 1 : -1;
        s3[ch] = s3[ch] + s2[ch];
        s2[ch] = s2[ch] + s1[ch];
        s1[ch] = s1[ch] + x;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            s1[c] = 0; s2[c] = 0; s3[c] = 0; drv_cnt[c] = 0;
            for (int k = 0; k < 4; k++) hist[c][k] = 0;
        end
        rcount = 0; sample_idx = 0; cyc = 0; last_valid = -1;
        expq_l.delete();
        expq_r.delete();
        prev_pclk = 1'b0;
        gen_bit(1, cur_bit);
        pdm_data = cur_bit;
    endtask

    task automatic do_tick();
        longint e[2];
        longint c3;
        for (int c = 0; c < 2; c++) begin
            for (int k = 3; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = s3[c];
            c3 = hist[c][0] - 3 * hist[c][1] + 3 * hist[c][2] - hist[c][3];
            e[c] = clamp16(c3 >>> 3);
        end
`ifndef AQP_PDM_STEREO_EN
        e[1] = e[0];
`endif
        expq_l.push_back(e[0]);
        expq_r.push_back(e[1]);
        tick_cnt++;
    endtask

    task automatic handle_valid();
        longint el, er, gl, gr;
        gl = longint'($signed(left_data));
        gr = longint'($signed(right_data));
        if (expq_l.size() == 0) begin
            check("unexpected_valid", 1, 0);
        end else begin
            el = expq_l.pop_front();
            er = expq_r.pop_front();
            sample_idx++;
            check("left_model", gl, el);
            check("right_model", gr, er);
            if (sample_idx >= 4) begin
                case (mode)
                    1: begin check("fs_pos_left", gl, 32767); check("fs_pos_right", gr, 32767); end
                    2: begin check("fs_neg_left", gl, -32768); check("fs_neg_right", gr, -32768); end
                    3: begin check("idle_left", gl, 0); check("idle_right", gr, 0); end
                    4: begin
                        check("sep_left", gl, 32767);
`ifdef AQP_PDM_STEREO_EN
                        check("sep_right", gr, -32768);
`else
                        check("sep_right", gr, 32767);
`endif
                    end
                    default: ;
                endcase
            end
        end
        if (last_valid >= 0 && !clear_period) check("valid_period", cyc - last_valid, PERIOD);
        last_valid = cyc;
        clear_period = 0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            model_reset();
            if (sample_valid) valid_in_reset++;
        end else begin
            cyc++;
            if (sample_valid) handle_valid();
            if (pdm_clk && !prev_pclk) begin
                consume(1, cur_bit);
                rcount++;
                if (rcount % DECIM == 0) do_tick();
                gen_bit(0, cur_bit);
                pdm_data = cur_bit;
            end else if (!pdm_clk && prev_pclk) begin
                consume(0, cur_bit);
                fall_cnt++;
                gen_bit(1, cur_bit);
                pdm_data = cur_bit;
            end
            prev_pclk = pdm_clk;
        end
    end

    task automatic wait_samples(input int n);
        int target;
        int budget;
        target = sample_idx + n;
        budget = (n + 1) * PERIOD + 200;
        while (sample_idx < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sample_idx < target) check("sample_timeout", sample_idx, target);
    endtask

    // Reset is released 1 ns after a rising edge; counts falling edges
    // until sample_valid is seen.
    task automatic release_and_time_first();
        int n;
        @(posedge clk);
        #1 reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < 2 * PERIOD);
        check("first_valid_latency", n, PERIOD);
    endtask

    task automatic restart(input int m);
        @(posedge clk);
        #1 reset = 1'b1;
        mode = m;
        repeat (3) @(posedge clk);
        release_and_time_first();
    endtask

    initial begin
        int hi, lo, bad_clk, bad_val, start;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pdm_clk", pdm_clk, 0);
        check("rst_left", left_data, 0);
        check("rst_right", right_data, 0);
        check("rst_valid", sample_valid, 0);
        enable = 1'b1;

        // Full scale positive, plus pdm_clk shape.
        mode = 1;
        @(posedge clk);
        #1 reset = 1'b0;
        hi = 0; lo = 0;
        for (int i = 0; i < 50 && !pdm_clk; i++) @(negedge clk);
        for (int i = 0; i < 50 && pdm_clk; i++) begin @(negedge clk); hi++; end
        for (int i = 0; i < 50 && !pdm_clk; i++) begin @(negedge clk); lo++; end
        check("pdm_clk_high", hi, CLK_DIV);
        check("pdm_clk_period", hi + lo, 2 * CLK_DIV);
        wait_samples(6);

        restart(2);
        wait_samples(5);
        restart(3);
        wait_samples(5);
        restart(4);
        wait_samples(5);

        // Random data with a disable window; the model keeps running, so
        // samples after re-enable prove the filter state was held.
        restart(0);
        wait_samples(3);
        start = fall_cnt;
        for (int i = 0; i < 100 && fall_cnt == start; i++) @(posedge clk);
        #1 enable = 1'b0;
        bad_clk = 0; bad_val = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pdm_clk) bad_clk++;
            if (sample_valid) bad_val++;
        end
        check("disabled_pdm_clk", bad_clk, 0);
        check("disabled_valid", bad_val, 0);
        clear_period = 1;
        @(posedge clk);
        #1 enable = 1'b1;
        wait_samples(4);

        // Reset while the comb is in its second stage.
        start = tick_cnt;
        for (int i = 0; i < 2 * PERIOD && tick_cnt == start; i++) @(posedge clk);
        check("tick_seen", tick_cnt != start, 1);
        #1 reset = 1'b1;
        valid_in_reset = 0;
        @(negedge clk);
        check("midrst_left", left_data, 0);
        check("midrst_right", right_data, 0);
        check("midrst_valid", sample_valid, 0);
        repeat (10) @(posedge clk);
        check("midrst_no_valid", valid_in_reset, 0);
        release_and_time_first();
        wait_samples(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
